// File: rtl/freq_gate_controller.sv
// freq_gate_controller: input synchroniser, rising-edge detector and gate
// timing FSM for a cascaded BCD frequency counter. Produces the per-edge
// count pulse, the gate enable, a clear pulse before each gate and a latch
// strobe after each gate. Supports single-shot and continuous measurement.
module freq_gate_controller #(
    parameter int unsigned GATE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic signal_in,
    input  logic start_in,
    input  logic continuous_in,
    output logic count_pulse_out,
    output logic count_enable_out,
    output logic counter_clear_out,
    output logic latch_out,
    output logic busy_out,
    output logic result_valid_out
);

    localparam int unsigned CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_LATCH
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       gate_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic                   valid_q;

    // Synchronise signal_in and keep one cycle of history for edge detection
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev tracks the synchronised level at all times, so a level held high
    // while idle never turns into a late edge when the gate opens.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate length counter: cleared in CLEAR, counts through GATE, saturates
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            gate_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            gate_cnt <= '0;
        end else if (state == ST_GATE && gate_cnt != GATE_LAST) begin
            gate_cnt <= gate_cnt + CNT_W'(1);
        end
    end

    // Sticky result-valid flag, set by the first completed latch
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            valid_q <= 1'b0;
        end else if (state == ST_LATCH) begin
            valid_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start_in || continuous_in) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_GATE;
            end
            ST_GATE: begin
                if (gate_cnt == GATE_LAST) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                state_nxt = continuous_in ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only (glitch-free strobes)
    always_comb begin
        count_pulse_out   = 1'b0;
        count_enable_out  = 1'b0;
        counter_clear_out = 1'b0;
        latch_out         = 1'b0;
        busy_out          = (state != ST_IDLE);
        result_valid_out  = valid_q;
        unique case (state)
            ST_CLEAR: counter_clear_out = 1'b1;
            ST_GATE: begin
                count_enable_out = 1'b1;
                count_pulse_out  = rise;
            end
            ST_LATCH: begin
                latch_out        = 1'b1;
                result_valid_out = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
